// File: rtl/boot_loader.sv
// Streams a length-prefixed byte image into memory as little-endian words and
// keeps the CPU held in reset until the image checksum has been verified.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_LEN_LO | waiting for low byte of the word count
// S_LEN_HI | waiting for high byte of the word count; range-checks it
// S_DATA   | collecting the four bytes of the current word
// S_WRITE  | single-cycle memory write of the assembled word
// S_CHECK  | waiting for the XOR checksum byte
// S_DONE   | image verified, CPU released (terminal)
// S_ERROR  | bad length or checksum, CPU kept in reset (terminal)
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter logic [15:0] MAX_WORDS = 16'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_w,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state, state_nx;
    logic [15:0] len_q;
    logic [23:0] word_q;
    logic [1:0]  byte_idx;
    logic [7:0]  chk_q;
    logic        xfer;
    logic [15:0] len_full;

    assign xfer     = in_valid && in_ready;
    assign len_full = {in_data, len_q[7:0]};

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_full > MAX_WORDS)     state_nx = S_ERROR;
                    else if (len_full == 16'd0)   state_nx = S_CHECK;
                    else                          state_nx = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && byte_idx == 2'd3) state_nx = S_WRITE;
            end
            S_WRITE: begin
                state_nx = (words_written + 16'd1 == len_q) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = (in_data == chk_q) ? S_DONE : S_ERROR;
            end
            default: state_nx = state;
        endcase
    end

    assign mem_w    = (state == S_WRITE);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);
    assign cpu_hold = (state != S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_LEN_LO;
            len_q         <= 16'd0;
            word_q        <= 24'd0;
            byte_idx      <= 2'd0;
            chk_q         <= 8'd0;
            words_written <= 16'd0;
            mem_addr      <= BASE_ADDR;
            mem_data      <= 32'd0;
        end else begin
            state <= state_nx;
            case (state)
                S_LEN_LO: if (xfer) len_q[7:0] <= in_data;
                S_LEN_HI: if (xfer) len_q[15:8] <= in_data;
                S_DATA: begin
                    if (xfer) begin
                        chk_q    <= chk_q ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_q[7:0]   <= in_data;
                            2'd1: word_q[15:8]  <= in_data;
                            2'd2: word_q[23:16] <= in_data;
                            default: begin
                                // Word and address are registered here so they are stable for the WRITE cycle.
                                mem_data <= {in_data, word_q};
                                mem_addr <= BASE_ADDR + {14'd0, words_written, 2'b00};
                            end
                        endcase
                    end
                end
                S_WRITE: words_written <= words_written + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Randomised self-checking bench for boot_loader; expected writes and final
// status are derived from the stream format by a byte-queue reference model.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_w;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    localparam int MAXW = 64;

    int n_checks = 0;
    int n_pass   = 0;
    int bad_rdy  = 0;

    logic [7:0]  img[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    boot_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(16'd64)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_w(mem_w), .cpu_hold(cpu_hold), .done(done), .error(error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Write capture plus ready/WRITE consistency observed on every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_w === 1'b1) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_data);
                if (in_ready !== 1'b0) bad_rdy++;
            end else if (done !== 1'b1 && error !== 1'b1 && in_ready !== 1'b1) begin
                bad_rdy++;
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        bad_rdy = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        bit r;
        if (gap > 0 && int'($urandom_range(0, 99)) < gap) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            #1 r = in_ready;
            @(negedge clk);
            if (r) ok = 1'b1;
        end
    endtask

    // Reference model: interpret img purely by the stream format rules.
    task automatic model(output bit e_done, output bit e_err, output int e_nw);
        int n;
        logic [7:0] x;
        n = {img[1], img[0]};
        exp_addr.delete();
        exp_data.delete();
        x = 8'h00;
        if (n > MAXW) begin
            e_done = 1'b0; e_err = 1'b1; e_nw = 0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(32'(4 * i));
            exp_data.push_back({img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]});
            for (int k = 0; k < 4; k++) x = x ^ img[2+4*i+k];
        end
        e_done = (img[2+4*n] == x);
        e_err  = !e_done;
        e_nw   = n;
    endtask

    task automatic make_image(input int n, input bit good);
        logic [7:0] x, b;
        img.delete();
        img.push_back(8'(n));
        img.push_back(8'(n >> 8));
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            img.push_back(b);
            x = x ^ b;
        end
        img.push_back(good ? x : (x ^ 8'h5A));
    endtask

    task automatic load_image(input int gap, input int settle, output bit ok,
                              output bit e_done, output bit e_err, output int e_nw);
        bit b_ok;
        model(e_done, e_err, e_nw);
        wr_addr.delete();
        wr_data.delete();
        ok = 1'b1;
        foreach (img[i]) begin
            send_byte(img[i], gap, b_ok);
            if (!b_ok) begin ok = 1'b0; break; end
        end
        in_valid = 1'b0;
        repeat (settle) @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if ({in_ready, cpu_hold, done, error, mem_w} !== 5'b11000)
            $display("FAIL reset_flags got=%b exp=11000", {in_ready, cpu_hold, done, error, mem_w});
        else n_pass++;
        n_checks++;
        if ({words_written, mem_addr, mem_data} !== 80'd0)
            $display("FAIL reset_regs ww=%0d addr=%h data=%h exp=0", words_written, mem_addr, mem_data);
        else n_pass++;
    endtask

    task automatic test_image(input string name, input int gap);
        bit ok, e_done, e_err;
        int e_nw;
        load_image(gap, 3, ok, e_done, e_err, e_nw);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL %s_timeout byte not accepted", name);
        else n_pass++;
        n_checks++;
        if (wr_addr.size() != exp_addr.size())
            $display("FAIL %s_nwrites got=%0d exp=%0d", name, wr_addr.size(), exp_addr.size());
        else n_pass++;
        for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
            n_checks++;
            if ({wr_addr[i], wr_data[i]} !== {exp_addr[i], exp_data[i]})
                $display("FAIL %s_write%0d got=%h@%h exp=%h@%h", name, i,
                         wr_data[i], wr_addr[i], exp_data[i], exp_addr[i]);
            else n_pass++;
        end
        n_checks++;
        if ({done, error, cpu_hold, in_ready} !== {e_done, e_err, ~e_done, 1'b0})
            $display("FAIL %s_status got=%b exp=%b", name, {done, error, cpu_hold, in_ready},
                     {e_done, e_err, ~e_done, 1'b0});
        else n_pass++;
        n_checks++;
        if (words_written !== 16'(e_nw))
            $display("FAIL %s_words_written got=%0d exp=%0d", name, words_written, e_nw);
        else n_pass++;
        n_checks++;
        if (bad_rdy !== 0) $display("FAIL %s_in_ready_vs_write got=%0d exp=0 violations", name, bad_rdy);
        else n_pass++;
    endtask

    task automatic test_nominal;
        do_reset();
        img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        test_image("nominal", 0);
    endtask

    task automatic test_bad_checksum;
        do_reset();
        img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        test_image("bad_chk", 0);
    endtask

    task automatic test_oversize;
        bit ok, e_done, e_err;
        int e_nw;
        do_reset();
        img = '{8'h41, 8'h00};
        load_image(0, 0, ok, e_done, e_err, e_nw);
        n_checks++;
        if ({ok, error, done, cpu_hold, in_ready} !== 5'b11010)
            $display("FAIL oversize_status got=%b exp=11010", {ok, error, done, cpu_hold, in_ready});
        else n_pass++;
        in_data = 8'h55; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({wr_addr.size() == 0, error, in_ready} !== 3'b110)
            $display("FAIL oversize_terminal got=%b exp=110", {wr_addr.size() == 0, error, in_ready});
        else n_pass++;
        do_reset();
        make_image(MAXW, 1'b1);
        test_image("max_len", 0);
    endtask

    task automatic test_zero_length;
        do_reset();
        img = '{8'h00, 8'h00, 8'h00};
        test_image("zero_len", 0);
        do_reset();
        img = '{8'h00, 8'h00, 8'h01};
        test_image("zero_len_bad", 0);
    endtask

    task automatic test_backpressure;
        logic [31:0] ref_d[$];
        for (int it = 0; it < 4; it++) begin
            do_reset();
            make_image(int'($urandom_range(1, 6)), it != 2);
            test_image("nogap", 0);
            ref_d = wr_data;
            do_reset();
            test_image("gaps", 40);
            n_checks++;
            if (wr_data != ref_d) $display("FAIL gaps_vs_nogap got=%0d words, exp=%0d identical words",
                                           wr_data.size(), ref_d.size());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset();
        img = '{8'h02, 8'h00, 8'h11, 8'h22};
        foreach (img[i]) send_byte(img[i], 0, ok);
        in_valid = 1'b0;
        do_reset();
        n_checks++;
        if ({words_written, in_ready, cpu_hold, done, error} !== {16'd0, 4'b1100})
            $display("FAIL reset_mid_state got=%h exp=%h", {words_written, in_ready, cpu_hold, done, error},
                     {16'd0, 4'b1100});
        else n_pass++;
        img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
        test_image("reset_mid", 0);
        n_checks++;
        if (wr_data.size() != 1 || wr_data[0] !== 32'hDDCCBBAA)
            $display("FAIL reset_mid_word got=%0d writes first=%h exp=1 write DDCCBBAA",
                     wr_data.size(), wr_data.size() > 0 ? wr_data[0] : 32'h0);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_oversize();
        test_zero_length();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
